// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-ported synchronous data RAM
// between N_CORES cores. Writes complete in the grant cycle. Reads take an issue
// cycle (ARB) plus a data cycle (RD). An atomic grant locks the RAM to its core
// until that core completes a non-atomic access.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   core_mem_read      - per-core read request
//   core_mem_write     - per-core write request (wins over read)
//   core_mem_atomic    - per-core lock-hold qualifier
//   core_mem_addr      - packed per-core addresses, core i at [i*ADDR_W +: ADDR_W]
//   core_mem_data_w    - packed per-core write data
//   core_mem_data_r    - read data broadcast, valid for the read owner in RD
//   core_mem_wait      - per-core stall
//   ram_addr/ram_data_w/ram_we/ram_re - RAM command, combinational from the grant
//   ram_data_r         - RAM read data, one cycle after ram_re
module mem_arbiter #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CORES-1:0]         core_mem_read,
    input  logic [N_CORES-1:0]         core_mem_write,
    input  logic [N_CORES-1:0]         core_mem_atomic,
    input  logic [N_CORES*ADDR_W-1:0]  core_mem_addr,
    input  logic [N_CORES*DATA_W-1:0]  core_mem_data_w,
    output logic [DATA_W-1:0]          core_mem_data_r,
    output logic [N_CORES-1:0]         core_mem_wait,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_data_w,
    output logic                       ram_we,
    output logic                       ram_re,
    input  logic [DATA_W-1:0]          ram_data_r
);

    localparam int unsigned PtrW = $clog2(N_CORES);

    typedef enum logic {StArb, StRd} state_e;

    state_e          state_q;
    logic [PtrW-1:0] rr_ptr_q;
    logic [PtrW-1:0] lock_owner_q;
    logic [PtrW-1:0] rd_owner_q;
    logic            lock_q;

    logic [N_CORES-1:0] req;
    logic [N_CORES-1:0] owner_mask;
    logic [N_CORES-1:0] eligible;
    logic [N_CORES-1:0] done;
    logic [PtrW-1:0]    winner;
    logic [PtrW-1:0]    next_ptr;
    logic               found;
    logic               grant;
    logic               win_write;
    logic               win_atomic;

    // (base + k) mod N_CORES, kept narrow so it indexes the per-core vectors directly.
    function automatic logic [PtrW-1:0] wrap_add(logic [PtrW-1:0] base, int unsigned k);
        return PtrW'((32'(base) + k) % N_CORES);
    endfunction

    always_comb begin
        req        = core_mem_read | core_mem_write;
        owner_mask = '0;
        owner_mask[lock_owner_q] = 1'b1;
        eligible   = lock_q ? (req & owner_mask) : req;

        // First eligible requester at or after rr_ptr, wrapping.
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < N_CORES; k++) begin
            if (!found && eligible[wrap_add(rr_ptr_q, k)]) begin
                found  = 1'b1;
                winner = wrap_add(rr_ptr_q, k);
            end
        end
        next_ptr   = wrap_add(winner, 1);
        win_write  = core_mem_write[winner];
        win_atomic = core_mem_atomic[winner];
        grant      = !rst && (state_q == StArb) && found;
    end

    always_comb begin
        done = '0;
        if (grant && win_write) begin
            done[winner] = 1'b1;
        end
        if (!rst && (state_q == StRd)) begin
            done[rd_owner_q] = 1'b1;
        end

        ram_we          = grant && win_write;
        ram_re          = grant && !win_write;
        ram_addr        = grant ? core_mem_addr[winner*ADDR_W +: ADDR_W] : '0;
        ram_data_w      = ram_we ? core_mem_data_w[winner*DATA_W +: DATA_W] : '0;
        core_mem_data_r = (!rst && (state_q == StRd)) ? ram_data_r : '0;
        core_mem_wait   = rst ? '0 : (req & ~done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StArb;
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= '0;
            rd_owner_q   <= '0;
        end else begin
            case (state_q)
                StArb: begin
                    if (found) begin
                        rr_ptr_q <= next_ptr;
                        if (win_atomic) begin
                            lock_q       <= 1'b1;
                            lock_owner_q <= winner;
                        end else if (lock_q && (winner == lock_owner_q)) begin
                            lock_q <= 1'b0;
                        end
                        if (!win_write) begin
                            rd_owner_q <= winner;
                            state_q    <= StRd;
                        end
                    end
                end
                StRd: begin
                    // Data returns this cycle; no grant, back to arbitration.
                    state_q <= StArb;
                end
                default: begin
                    state_q <= StArb;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int N = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    core_mem_read;
    logic [N-1:0]    core_mem_write;
    logic [N-1:0]    core_mem_atomic;
    logic [N*AW-1:0] core_mem_addr;
    logic [N*DW-1:0] core_mem_data_w;
    logic [DW-1:0]   core_mem_data_r;
    logic [N-1:0]    core_mem_wait;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_data_w;
    logic            ram_we;
    logic            ram_re;
    logic [DW-1:0]   ram_data_r;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } grant_t;

    grant_t exp_q[$];

    logic [DW-1:0] mem [0:4095];

    mem_arbiter #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_mem_read   (core_mem_read),
        .core_mem_write  (core_mem_write),
        .core_mem_atomic (core_mem_atomic),
        .core_mem_addr   (core_mem_addr),
        .core_mem_data_w (core_mem_data_w),
        .core_mem_data_r (core_mem_data_r),
        .core_mem_wait   (core_mem_wait),
        .ram_addr        (ram_addr),
        .ram_data_w      (ram_data_w),
        .ram_we          (ram_we),
        .ram_re          (ram_re),
        .ram_data_r      (ram_data_r)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: read data one cycle after ram_re.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[11:0]] <= ram_data_w;
        if (ram_re) ram_data_r <= mem[ram_addr[11:0]];
    end

    // Scoreboard: every RAM strobe must match the next expected grant.
    always @(negedge clk) begin
        if (!rst && (ram_we || ram_re)) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL grant_unexpected: we=%0b re=%0b addr=%h, none expected",
                         ram_we, ram_re, ram_addr);
            end else begin
                grant_t e;
                e = exp_q.pop_front();
                if ({ram_we, ram_re, ram_addr} !== {e.we, !e.we, e.addr}
                    || (e.we && ram_data_w !== e.data))
                    $display("FAIL grant: got we=%0b re=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                             ram_we, ram_re, ram_addr, ram_data_w, e.we, e.addr, e.data);
                else passes++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic rd, input logic wr, input logic at,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_mem_read[i]          = rd;
        core_mem_write[i]         = wr;
        core_mem_atomic[i]        = at;
        core_mem_addr[i*AW +: AW] = a;
        core_mem_data_w[i*DW +: DW] = d;
    endtask

    task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        grant_t g;
        g.we = we; g.addr = a; g.data = d;
        exp_q.push_back(g);
    endtask

    task automatic clear_inputs();
        core_mem_read = '0; core_mem_write = '0; core_mem_atomic = '0;
        core_mem_addr = '0; core_mem_data_w = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        drive(1, 1'b0, 1'b1, 1'b0, 16'h0abc, 32'h1111_2222);
        step();
        @(negedge clk);
        checks++;
        if ({ram_we, ram_re, core_mem_wait, ram_addr, ram_data_w, core_mem_data_r} !== '0)
            $display("FAIL reset_outputs: we=%0b re=%0b wait=%b addr=%h wd=%h rd=%h, want all 0",
                     ram_we, ram_re, core_mem_wait, ram_addr, ram_data_w, core_mem_data_r);
        else passes++;
        checks++;
        if ({dut.rr_ptr_q, dut.lock_q} !== '0)
            $display("FAIL reset_regs: rr_ptr=%0d lock=%0b, want 0/0", dut.rr_ptr_q, dut.lock_q);
        else passes++;
        step();
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        drive(0, 1'b0, 1'b1, 1'b0, 16'h0010, 32'hDEAD_BEEF);
        push(1'b1, 16'h0010, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || core_mem_wait[0] !== 1'b0)
            $display("FAIL wr_grant: we=%0b wait0=%0b, want 1/0", ram_we, core_mem_wait[0]);
        else passes++;
        step();
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
        push(1'b0, 16'h0010, 32'h0);
        @(negedge clk);
        checks++;
        if (ram_re !== 1'b1 || core_mem_wait[0] !== 1'b1)
            $display("FAIL rd_issue: re=%0b wait0=%0b, want 1/1", ram_re, core_mem_wait[0]);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if (core_mem_data_r !== 32'hDEAD_BEEF || core_mem_wait[0] !== 1'b0 || ram_re !== 1'b0)
            $display("FAIL rd_data: data=%h wait0=%0b re=%0b, want deadbeef/0/0",
                     core_mem_data_r, core_mem_wait[0], ram_re);
        else passes++;
        step();
        clear_inputs();
    endtask

    task automatic test_four_writes();
        int wcnt[N];
        logic [N-1:0] expw;
        do_reset();
        for (int k = 0; k < N; k++) begin
            wcnt[k] = 0;
            drive(k, 1'b0, 1'b1, 1'b0, 16'(16'h0100 + k), 32'hA000_0000 + k);
            push(1'b1, 16'(16'h0100 + k), 32'hA000_0000 + k);
        end
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            expw = '0;
            for (int j = c + 1; j < N; j++) expw[j] = 1'b1;
            checks++;
            if (core_mem_wait !== expw)
                $display("FAIL four_wait_c%0d: wait=%b, want %b", c, core_mem_wait, expw);
            else passes++;
            for (int j = 0; j < N; j++) if (core_mem_wait[j]) wcnt[j]++;
            step();
            drive(c, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (wcnt[k] != k)
                $display("FAIL four_wait_cycles_core%0d: got %0d, want %0d", k, wcnt[k], k);
            else passes++;
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd0)
            $display("FAIL four_rr_ptr: got %0d, want 0", dut.rr_ptr_q);
        else passes++;
    endtask

    task automatic test_read_contention();
        int w1 = 0;
        // One write from core 1 moves rr_ptr to 2.
        drive(1, 1'b0, 1'b1, 1'b0, 16'h0200, 32'h1234_5678);
        push(1'b1, 16'h0200, 32'h1234_5678);
        step();
        clear_inputs();
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0200, 32'h0);
        drive(2, 1'b1, 1'b0, 1'b0, 16'h0102, 32'h0);
        push(1'b0, 16'h0102, 32'h0);
        push(1'b0, 16'h0200, 32'h0);
        @(negedge clk);
        checks++;
        if (core_mem_wait !== 4'b0110 || ram_addr !== 16'h0102)
            $display("FAIL rc_c0: wait=%b addr=%h, want 0110/0102", core_mem_wait, ram_addr);
        else passes++;
        w1 += int'(core_mem_wait[1]);
        step();
        @(negedge clk);
        checks++;
        if (core_mem_data_r !== 32'hA000_0002 || core_mem_wait !== 4'b0010)
            $display("FAIL rc_c1: data=%h wait=%b, want a0000002/0010", core_mem_data_r, core_mem_wait);
        else passes++;
        w1 += int'(core_mem_wait[1]);
        step();
        drive(2, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (core_mem_wait !== 4'b0010 || ram_re !== 1'b1)
            $display("FAIL rc_c2: wait=%b re=%0b, want 0010/1", core_mem_wait, ram_re);
        else passes++;
        w1 += int'(core_mem_wait[1]);
        step();
        @(negedge clk);
        checks++;
        if (core_mem_data_r !== 32'h1234_5678 || core_mem_wait !== 4'b0000)
            $display("FAIL rc_c3: data=%h wait=%b, want 12345678/0000", core_mem_data_r, core_mem_wait);
        else passes++;
        w1 += int'(core_mem_wait[1]);
        step();
        clear_inputs();
        checks++;
        if (w1 != 3) $display("FAIL rc_wait1_cycles: got %0d, want 3", w1);
        else passes++;
    endtask

    task automatic test_atomic_lock();
        // rr_ptr is 2 here, so core 0 wins over core 1.
        drive(0, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h0);
        drive(1, 1'b0, 1'b1, 1'b0, 16'h0300, 32'h0000_0055);
        push(1'b0, 16'h0010, 32'h0);
        @(negedge clk);
        checks++;
        if (core_mem_wait !== 4'b0011 || ram_re !== 1'b1)
            $display("FAIL at_c0: wait=%b re=%0b, want 0011/1", core_mem_wait, ram_re);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if (core_mem_data_r !== 32'hDEAD_BEEF || core_mem_wait !== 4'b0010)
            $display("FAIL at_c1: data=%h wait=%b, want deadbeef/0010", core_mem_data_r, core_mem_wait);
        else passes++;
        step();
        drive(0, 1'b0, 1'b1, 1'b0, 16'h0020, 32'h0000_0077);
        push(1'b1, 16'h0020, 32'h0000_0077);
        push(1'b1, 16'h0300, 32'h0000_0055);
        @(negedge clk);
        // rr_ptr points at core 1, yet the lock keeps it out.
        checks++;
        if (core_mem_wait !== 4'b0010 || ram_addr !== 16'h0020 || dut.lock_q !== 1'b1)
            $display("FAIL at_c2: wait=%b addr=%h lock=%0b, want 0010/0020/1",
                     core_mem_wait, ram_addr, dut.lock_q);
        else passes++;
        step();
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (core_mem_wait !== 4'b0000 || ram_we !== 1'b1 || dut.lock_q !== 1'b0)
            $display("FAIL at_c3: wait=%b we=%0b lock=%0b, want 0000/1/0",
                     core_mem_wait, ram_we, dut.lock_q);
        else passes++;
        step();
        clear_inputs();
    endtask

    task automatic test_read_write_same();
        // rr_ptr is 2; core 3 is the only requester and wraps rr_ptr to 0.
        drive(3, 1'b1, 1'b1, 1'b0, 16'h0400, 32'hCAFE_F00D);
        push(1'b1, 16'h0400, 32'hCAFE_F00D);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_re !== 1'b0 || core_mem_wait[3] !== 1'b0)
            $display("FAIL rw_same: we=%0b re=%0b wait3=%0b, want 1/0/0",
                     ram_we, ram_re, core_mem_wait[3]);
        else passes++;
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dut.rr_ptr_q !== 2'd0 || core_mem_data_r !== '0)
            $display("FAIL rw_wrap: rr_ptr=%0d data_r=%h, want 0/0", dut.rr_ptr_q, core_mem_data_r);
        else passes++;
        step();
    endtask

    task automatic test_reset_mid_read();
        drive(2, 1'b1, 1'b0, 1'b0, 16'h0102, 32'h0);
        push(1'b0, 16'h0102, 32'h0);
        step();
        drive(1, 1'b0, 1'b1, 1'b0, 16'h0500, 32'h0BAD_CAFE);
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_we, ram_re, core_mem_wait, ram_addr, ram_data_w, core_mem_data_r} !== '0)
            $display("FAIL mid_reset_outputs: we=%0b re=%0b wait=%b addr=%h rd=%h, want all 0",
                     ram_we, ram_re, core_mem_wait, ram_addr, core_mem_data_r);
        else passes++;
        step();
        rst = 1'b0;
        drive(2, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        push(1'b1, 16'h0500, 32'h0BAD_CAFE);
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || core_mem_wait !== 4'b0000 || ram_addr !== 16'h0500)
            $display("FAIL post_reset_write: we=%0b wait=%b addr=%h, want 1/0000/0500",
                     ram_we, core_mem_wait, ram_addr);
        else passes++;
        step();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_four_writes();
        test_read_contention();
        test_atomic_lock();
        test_read_write_same();
        test_reset_mid_read();
        step();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL grants_outstanding: %0d expected grants never seen, want 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
